// File: rtl/ising_pkg.sv
// Shared constants, reader state encoding and the Q-format phase threshold helper
// for the Ising result reader (optional cut accumulator: ISING_READER_CUT_EN).
package ising_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int FRAC_BITS_DEF  = 16;

  // Q16.16 reference constants
  localparam logic signed [31:0] ONE     = 32'sh0001_0000;
  localparam logic signed [31:0] PI      = 32'sh0003_243F;
  localparam logic signed [31:0] HALF_PI = 32'sh0001_921F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_PRESENT = 2'd2
  } reader_state_t;

  // Rescales the Q16.16 HALF_PI constant to the requested number of fraction bits.
  function automatic logic signed [63:0] half_pi_q(input int frac_bits);
    logic signed [63:0] base;
    base = 64'(HALF_PI);
    if (frac_bits >= 16) begin
      return base <<< (frac_bits - 16);
    end else begin
      return base >>> (16 - frac_bits);
    end
  endfunction

endpackage

// File: rtl/ising_spin_quantizer.sv
// Maps one oscillator phase to a spin: +1 (1) strictly inside (-pi/2, pi/2), else -1 (0).
module ising_spin_quantizer
  import ising_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic signed [DATA_WIDTH-1:0] phase,
  output logic                         spin
);

  localparam logic signed [DATA_WIDTH-1:0] HP = DATA_WIDTH'(half_pi_q(FRAC_BITS));

  // Strict bounds: exactly +/-pi/2 quantizes to -1.
  always_comb begin
    spin = (phase < HP) && (phase > -HP);
  end

endmodule

// File: rtl/ising_result_reader.sv
// Quantizes final Ising phases, accumulates the Ising energy over all (i,j) pairs and
// presents spins/energy/cut on a valid/ready handshake. Cut accumulator: ISING_READER_CUT_EN.
module ising_result_reader
  import ising_pkg::*;
#(
  parameter int N          = 16,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int EW         = DATA_WIDTH + 2 * $clog2(N) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         done_in,
  input  logic [N*DATA_WIDTH-1:0]      phi_in,
  input  logic [N*N*DATA_WIDTH-1:0]    J,
  output logic                         busy,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [N-1:0]                 spins,
  output logic signed [EW-1:0]         energy,
  output logic signed [EW-1:0]         cut,
  output logic                         overrun
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  reader_state_t state, state_next;
  logic [N-1:0]  quant;
  logic [IW-1:0] row, col;
  logic signed [EW-1:0]         acc, acc_next, term;
  logic signed [DATA_WIDTH-1:0] coef;
  logic start, last_pair, same;

  for (genvar g = 0; g < N; g++) begin : g_quant
    ising_spin_quantizer #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
    ) u_quant (
      .phase (phi_in[g*DATA_WIDTH +: DATA_WIDTH]),
      .spin  (quant[g])
    );
  end

  // Next-state decode and start/finish strobes.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    last_pair  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (done_in) begin
          state_next = ST_ACCUM;
          start      = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if ((row == LAST_IDX) && (col == LAST_IDX)) begin
          state_next = ST_PRESENT;
          last_pair  = 1'b1;
        end else begin
          state_next = ST_ACCUM;
        end
      end
      ST_PRESENT: begin
        if (res_valid && res_ready) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_PRESENT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; busy/res_valid are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_next;
      busy      <= (state_next != ST_IDLE);
      res_valid <= (state_next == ST_PRESENT);
    end
  end

  // Per-pair contribution; the diagonal contributes nothing.
  always_comb begin
    coef = J[(int'(row) * N + int'(col)) * DATA_WIDTH +: DATA_WIDTH];
    same = (spins[row] == spins[col]);
    if (row == col) begin
      term = {EW{1'b0}};
    end else begin
      term = EW'(coef);
    end
    if (same) begin
      acc_next = acc + term;
    end else begin
      acc_next = acc - term;
    end
  end

  // Capture, pair walk, energy accumulation and sticky overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spins   <= {N{1'b0}};
      acc     <= {EW{1'b0}};
      energy  <= {EW{1'b0}};
      row     <= {IW{1'b0}};
      col     <= {IW{1'b0}};
      overrun <= 1'b0;
    end else begin
      if (done_in && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      if (start) begin
        spins <= quant;
        acc   <= {EW{1'b0}};
        row   <= {IW{1'b0}};
        col   <= {IW{1'b0}};
      end else if (state == ST_ACCUM) begin
        acc <= acc_next;
        if (last_pair) begin
          energy <= -(acc_next >>> 1);
          row    <= {IW{1'b0}};
          col    <= {IW{1'b0}};
        end else if (col == LAST_IDX) begin
          col <= {IW{1'b0}};
          row <= row + IW'(1);
        end else begin
          col <= col + IW'(1);
        end
      end
    end
  end

`ifdef ISING_READER_CUT_EN
  logic signed [EW-1:0] cacc, cacc_next;

  // Cut weight counts only pairs with opposite spins.
  always_comb begin
    if (same) begin
      cacc_next = cacc;
    end else begin
      cacc_next = cacc + term;
    end
  end

  // Cut accumulator and presented cut value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cacc <= {EW{1'b0}};
      cut  <= {EW{1'b0}};
    end else begin
      if (start) begin
        cacc <= {EW{1'b0}};
      end else if (state == ST_ACCUM) begin
        cacc <= cacc_next;
        if (last_pair) begin
          cut <= cacc_next >>> 1;
        end
      end
    end
  end
`else
  assign cut = {EW{1'b0}};
`endif

endmodule

// File: tb/tb_ising_result_reader.sv
// Directed table-driven bench for ising_result_reader (N=4), plus latency, hold,
// overrun, mid-run reset and back-to-back handshake sequences.
module tb_ising_result_reader;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int EW = DW + 2 * $clog2(N) + 1;

  localparam logic [31:0] P_PI  = 32'h0003_243F;
  localparam logic [31:0] P_HP  = 32'h0001_921F;
  localparam logic [31:0] P_ONE = 32'h0001_0000;

  typedef struct {
    logic [N*DW-1:0]   phi;
    logic [N*N*DW-1:0] jm;
    logic [N-1:0]      exp_spins;
    logic [EW-1:0]     exp_energy;
    logic [EW-1:0]     exp_cut;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, done_in, res_ready;
  logic [N*DW-1:0]   phi_in;
  logic [N*N*DW-1:0] J;
  logic busy, res_valid, overrun;
  logic [N-1:0] spins;
  logic signed [EW-1:0] energy, cut;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[7];

  ising_result_reader #(.N(N), .DATA_WIDTH(DW), .FRAC_BITS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .done_in   (done_in),
    .phi_in    (phi_in),
    .J         (J),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .spins     (spins),
    .energy    (energy),
    .cut       (cut),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [N*DW-1:0] pack_phi(input logic [31:0] p0, p1, p2, p3);
    return {p3, p2, p1, p0};
  endfunction

  function automatic logic [N*N*DW-1:0] make_j(input logic [31:0] off, input logic [31:0] diag);
    logic [N*N*DW-1:0] m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[(i*N+j)*DW +: DW] = (i == j) ? diag : off;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!res_valid && k < 64) begin
      step();
      k++;
    end
    n_vec++;
    if (!res_valid) begin
      n_err++;
      $display("FAIL %s: res_valid timeout, got 0, expected 1", name);
    end
  endtask

  function automatic logic [EW-1:0] cut_exp(input logic [EW-1:0] c);
`ifdef ISING_READER_CUT_EN
    return c;
`else
    return {EW{1'b0}} & c;
`endif
  endfunction

  task automatic run_vec(input int idx);
    phi_in  = tbl[idx].phi;
    J       = tbl[idx].jm;
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    wait_valid($sformatf("vec%0d_valid", idx));
    chk($sformatf("vec%0d_spins", idx), 64'(spins), 64'(tbl[idx].exp_spins));
    chk($sformatf("vec%0d_energy", idx), 64'(energy), 64'(signed'(tbl[idx].exp_energy)));
    chk($sformatf("vec%0d_cut", idx), 64'(cut), 64'(signed'(cut_exp(tbl[idx].exp_cut))));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    logic [N*N*DW-1:0] jlsb;
    logic ever_valid;

    jlsb = {N*N*DW{1'b0}};
    jlsb[(0*N+1)*DW +: DW] = 32'h0000_0001;

    tbl[0] = '{pack_phi(32'h0, 32'h0, 32'h0, 32'h0), make_j(P_ONE, 32'h0),
               4'b1111, -37'sh6_0000, 37'sh0};
    tbl[1] = '{pack_phi(32'h0, P_PI, 32'h0, P_PI), make_j(P_ONE, 32'h0),
               4'b0101, 37'sh2_0000, 37'sh4_0000};
    tbl[2] = '{pack_phi(P_HP, P_HP - 32'h1, -P_HP, -P_HP + 32'h1), make_j(P_ONE, 32'h0),
               4'b1010, 37'sh2_0000, 37'sh4_0000};
    tbl[3] = '{pack_phi(32'h0, 32'h0, 32'h0, 32'h0), make_j(P_ONE, 32'h7FFF_0000),
               4'b1111, -37'sh6_0000, 37'sh0};
    tbl[4] = '{pack_phi(32'h0, P_PI, 32'h0, P_PI), make_j(-P_ONE, 32'h0),
               4'b0101, -37'sh2_0000, -37'sh4_0000};
    tbl[5] = '{pack_phi(32'h0, P_PI, 32'h0, 32'h0), jlsb,
               4'b1101, 37'sh1, 37'sh0};
    tbl[6] = '{pack_phi(P_PI, -P_PI, 32'h7FFF_FFFF, 32'h8000_0000), make_j(P_ONE, 32'h0),
               4'b0000, -37'sh6_0000, 37'sh0};

    rst_n = 1'b0; done_in = 1'b0; res_ready = 1'b0;
    phi_in = tbl[0].phi; J = tbl[0].jm;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_spins", 64'(spins), 64'd0);
    chk("rst_energy", 64'(energy), 64'd0);
    chk("rst_cut", 64'(cut), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    step();

    for (int v = 0; v < 7; v++) run_vec(v);

    // Latency, hold under backpressure, overrun during hold
    phi_in = tbl[1].phi; J = tbl[1].jm;
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    phi_in = tbl[0].phi;
    for (int k = 1; k <= 16; k++) chk($sformatf("lat_valid_c%0d", k), 64'(res_valid), 64'd0);
    for (int k = 1; k <= 16; k++) if (k < 16) step();
    step();
    chk("lat_valid_c17", 64'(res_valid), 64'd1);
    chk("hold_overrun_pre", 64'(overrun), 64'd0);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("hold_valid_%0d", k), 64'(res_valid), 64'd1);
      chk($sformatf("hold_spins_%0d", k), 64'(spins), 64'(4'b0101));
      chk($sformatf("hold_energy_%0d", k), 64'(energy), 64'(37'sh2_0000));
      done_in = (k == 3);
      step();
    end
    done_in = 1'b0;
    chk("hold_overrun", 64'(overrun), 64'd1);
    chk("hold_spins_after", 64'(spins), 64'(4'b0101));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("hs_valid_low", 64'(res_valid), 64'd0);
    chk("hs_busy_low", 64'(busy), 64'd0);

    // Reset during the fifth ACCUM cycle
    phi_in = tbl[0].phi; J = tbl[0].jm;
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    for (int k = 0; k < 4; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_overrun", 64'(overrun), 64'd0);
    ever_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      ever_valid = ever_valid | res_valid;
      step();
    end
    chk("mid_rst_no_valid", 64'(ever_valid), 64'd0);
    run_vec(1);

    // done_in on the handshake cycle is dropped; the next cycle is accepted
    res_ready = 1'b1;
    phi_in = tbl[0].phi; J = tbl[0].jm;
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    wait_valid("b2b_first_valid");
    chk("b2b_first_spins", 64'(spins), 64'(4'b1111));
    phi_in = tbl[1].phi;
    done_in = 1'b1;
    step();
    chk("b2b_overrun", 64'(overrun), 64'd1);
    chk("b2b_busy_idle", 64'(busy), 64'd0);
    chk("b2b_valid_low", 64'(res_valid), 64'd0);
    chk("b2b_spins_kept", 64'(spins), 64'(4'b1111));
    step();
    done_in = 1'b0;
    chk("b2b_accepted", 64'(busy), 64'd1);
    wait_valid("b2b_second_valid");
    chk("b2b_second_spins", 64'(spins), 64'(4'b0101));
    chk("b2b_second_energy", 64'(energy), 64'(37'sh2_0000));
    step();
    res_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ising_result_reader.md
ISING_RESULT_READER -- requirements
Module: ising_result_reader

Interface
REQ-001 Parameter N, default 16, oscillator count; DATA_WIDTH, default 32, phase/coupling width; FRAC_BITS, default 16, Q-format fraction bits.
REQ-002 Parameter EW, default DATA_WIDTH+2*$clog2(N)+1, energy/cut width.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 done_in  in  1  single-cycle pulse from the Ising machine that phases are final.
REQ-006 phi_in  in  N x DATA_WIDTH signed  final phases, Q16.16, valid when done_in=1.
REQ-007 J  in  N x N x DATA_WIDTH signed  coupling matrix, static from done_in until result accepted.
REQ-008 busy  out  1  high in any state except IDLE.
REQ-009 res_valid  out  1  result available; res_ready  in  1  consumer accepts.
REQ-010 spins  out  N  bit i=1 means s_i=+1, 0 means s_i=-1.
REQ-011 energy  out  EW signed  Ising energy, Q16.16.
REQ-012 cut  out  EW signed  cut weight, Q16.16 (see Configuration).
REQ-013 overrun  out  1  sticky: done_in arrived while not IDLE.

Function
REQ-014 FSM states IDLE, ACCUM, PRESENT; IDLE->ACCUM on done_in=1; ACCUM->PRESENT after N*N accumulate cycles; PRESENT->IDLE when res_valid&&res_ready.
REQ-015 On done_in in IDLE: spins register loads quantized phi_in, accumulators clear, i=j=0.
REQ-016 Quantization: s_i=+1 iff -HALF_PI < phi_in[i] < HALF_PI (strict, HALF_PI=0x0001921F); else -1.
REQ-017 ACCUM: one (i,j) pair per cycle, j inner, j fastest, row-major; diagonal i==j adds 0.
REQ-018 Per pair: acc += J[i][j] if s_i==s_j, else acc -= J[i][j]; acc is EW bits signed, no saturation.
REQ-019 On ACCUM exit: energy <= -(acc >>> 1) (arithmetic shift).
REQ-020 Latency: done_in sampled at cycle t -> ACCUM cycles t+1..t+N*N -> res_valid first high at t+N*N+1.
REQ-021 res_valid high only in PRESENT; spins, energy, cut stable while res_valid=1 and res_ready=0.
REQ-022 Handshake completes in the cycle res_valid&&res_ready; res_valid low next cycle; next done_in accepted from that cycle onward.
REQ-023 done_in in ACCUM or PRESENT (incl. handshake cycle): ignored, no capture, overrun<=1.
REQ-024 overrun clears only on reset.

Reset
REQ-025 rst_n=0 at posedge: state IDLE, busy=0, res_valid=0, spins=0, energy=0, cut=0, overrun=0, acc and indices 0.
REQ-026 Reset mid-ACCUM or mid-PRESENT abandons the result; no res_valid until a new done_in.

Configuration
REQ-027 Macro ISING_READER_CUT_EN defined: second accumulator adds J[i][j] when s_i!=s_j during ACCUM; cut <= cacc >>> 1 on ACCUM exit.
REQ-028 Macro undefined: cut accumulator absent, cut port tied to 0; ports unchanged.

Structure
REQ-029 Package ising_pkg holds ONE, PI, HALF_PI, DATA_WIDTH/FRAC_BITS defaults, and reader state enum.
REQ-030 Sub-module ising_spin_quantizer: combinational, one phase in, one spin bit out, instantiated N times.

Verification (N=4)
REQ-031 phi all 0, J off-diag 0x00010000 -> spins=4'b1111, energy=-0x00060000, cut=0.
REQ-032 phi={0,PI,0,PI} (idx0..3), same J -> spins=4'b0101, energy=0x00020000, cut=0x00040000 (CUT_EN).
REQ-033 phi={HALF_PI, HALF_PI-1, -HALF_PI, -HALF_PI+1} -> spins=4'b1010.
REQ-034 done_in at cycle t -> res_valid first 1 at t+17; res_ready low 10 cycles -> outputs stable; done_in pulse during hold -> overrun=1, result unchanged.
REQ-035 rst_n=0 at 5th ACCUM cycle -> next cycle busy=0, res_valid=0, overrun=0; new done_in gives correct result.
REQ-036 res_ready tied 1, done_in on handshake cycle -> overrun=1, no capture; done_in next cycle -> accepted.
